// File: rtl/rf_pkg.sv
// Shared register-file types: default widths, writeback source tag and write request.
package rf_pkg;

    localparam int unsigned RF_WIDTH      = 32;
    localparam int unsigned RF_DEPTH_BITS = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LSU  = 2'd2
    } wr_src_t;

    typedef struct packed {
        logic [RF_DEPTH_BITS-1:0] addr;
        logic [RF_WIDTH-1:0]      data;
    } wr_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for long-latency writebacks; pointers wrap modulo DEPTH.
module rf_wb_fifo #(
    parameter int unsigned DATA_W = 37,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            din,
    input  logic                         pop,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CW'(1);
        end
    end

    // Storage is not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges pipeline and long-latency writebacks onto the single register-file write port.
// Optional per-register pending scoreboard enabled by `define RF_WB_SCOREBOARD_EN.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH        = RF_WIDTH,
    parameter int unsigned DEPTH_BITS   = RF_DEPTH_BITS,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                PipeWrEn,
    input  logic [DEPTH_BITS-1:0]               PipeWrAddress,
    input  logic [WIDTH-1:0]                    PipeWrData,
    input  logic                                LsuValid,
    output logic                                LsuReady,
    input  logic [DEPTH_BITS-1:0]               LsuWrAddress,
    input  logic [WIDTH-1:0]                    LsuWrData,
    input  logic                                IssueEn,
    input  logic [DEPTH_BITS-1:0]               IssueAddress,
    input  logic [DEPTH_BITS-1:0]               QueryAddress1,
    input  logic [DEPTH_BITS-1:0]               QueryAddress2,
    output logic                                Busy1,
    output logic                                Busy2,
    output logic                                StallReq,
    output logic                                WrEn,
    output logic [DEPTH_BITS-1:0]               WrAddress,
    output logic [WIDTH-1:0]                    WrData,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     FifoCount
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned REQ_W = DEPTH_BITS + WIDTH;

    typedef struct packed {
        logic [DEPTH_BITS-1:0] addr;
        logic [WIDTH-1:0]      data;
    } req_t;

    req_t          lsu_req;
    req_t          head;
    wr_src_t       src;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] age;
    logic [AW-1:0] age_nxt;

    assign LsuReady  = !rst && !full;
    assign FifoCount = count;
    assign lsu_req   = '{addr: LsuWrAddress, data: LsuWrData};
    // x0 transfers complete the handshake but are never queued.
    assign push      = LsuValid && LsuReady && (LsuWrAddress != '0);

    rf_wb_fifo #(
        .DATA_W (REQ_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (lsu_req),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Pipeline wins unless it targets x0; FIFO head fills the idle slots.
    always_comb begin
        src = SRC_NONE;
        pop = 1'b0;
        if (PipeWrEn && (PipeWrAddress != '0)) begin
            src = SRC_PIPE;
        end else if (!empty) begin
            src = SRC_LSU;
            pop = 1'b1;
        end
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (pop && !push) count_nxt = count - CW'(1);
    end

    // Head age saturates at the limit; a fresh push into an empty FIFO starts at 0.
    always_comb begin
        age_nxt = '0;
        if (!empty && !pop) begin
            age_nxt = (age == AW'(STARVE_LIMIT)) ? age : age + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WrEn      <= 1'b0;
            WrAddress <= '0;
            WrData    <= '0;
            StallReq  <= 1'b0;
            age       <= '0;
        end else begin
            age      <= age_nxt;
            StallReq <= (age_nxt >= AW'(STARVE_LIMIT)) || (count_nxt == CW'(FIFO_DEPTH));
            WrEn     <= (src != SRC_NONE);
            case (src)
                SRC_PIPE: begin
                    WrAddress <= PipeWrAddress;
                    WrData    <= PipeWrData;
                end
                SRC_LSU: begin
                    WrAddress <= head.addr;
                    WrData    <= head.data;
                end
                default: ;
            endcase
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [(1 << DEPTH_BITS)-1:0] pending;
    logic [(1 << DEPTH_BITS)-1:0] pending_nxt;

    // A fresh issue to the same register outranks the retiring LSU result.
    always_comb begin
        pending_nxt = pending;
        if (src == SRC_LSU) pending_nxt[head.addr] = 1'b0;
        if (IssueEn && (IssueAddress != '0)) pending_nxt[IssueAddress] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    assign Busy1 = pending[QueryAddress1];
    assign Busy2 = pending[QueryAddress2];
`else
    logic unused_sb;
    assign unused_sb = ^{IssueEn, IssueAddress, QueryAddress1, QueryAddress2};
    assign Busy1     = 1'b0;
    assign Busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter; Busy expectations follow RF_WB_SCOREBOARD_EN.
module tb_rf_writeback_arbiter;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned DEPTH_BITS   = 5;
    localparam int unsigned FIFO_DEPTH   = 2;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef RF_WB_SCOREBOARD_EN
    localparam logic SB_ON = 1'b1;
`else
    localparam logic SB_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  PipeWrEn;
    logic [DEPTH_BITS-1:0] PipeWrAddress;
    logic [WIDTH-1:0]      PipeWrData;
    logic                  LsuValid;
    logic                  LsuReady;
    logic [DEPTH_BITS-1:0] LsuWrAddress;
    logic [WIDTH-1:0]      LsuWrData;
    logic                  IssueEn;
    logic [DEPTH_BITS-1:0] IssueAddress;
    logic [DEPTH_BITS-1:0] QueryAddress1;
    logic [DEPTH_BITS-1:0] QueryAddress2;
    logic                  Busy1;
    logic                  Busy2;
    logic                  StallReq;
    logic                  WrEn;
    logic [DEPTH_BITS-1:0] WrAddress;
    logic [WIDTH-1:0]      WrData;
    logic [1:0]            FifoCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(
        .WIDTH        (WIDTH),
        .DEPTH_BITS   (DEPTH_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PipeWrEn      (PipeWrEn),
        .PipeWrAddress (PipeWrAddress),
        .PipeWrData    (PipeWrData),
        .LsuValid      (LsuValid),
        .LsuReady      (LsuReady),
        .LsuWrAddress  (LsuWrAddress),
        .LsuWrData     (LsuWrData),
        .IssueEn       (IssueEn),
        .IssueAddress  (IssueAddress),
        .QueryAddress1 (QueryAddress1),
        .QueryAddress2 (QueryAddress2),
        .Busy1         (Busy1),
        .Busy2         (Busy2),
        .StallReq      (StallReq),
        .WrEn          (WrEn),
        .WrAddress     (WrAddress),
        .WrData        (WrData),
        .FifoCount     (FifoCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PipeWrEn = 1'b0; PipeWrAddress = '0; PipeWrData = '0;
        LsuValid = 1'b1; LsuWrAddress = 5'd3; LsuWrData = 32'h33;
        IssueEn = 1'b0; IssueAddress = '0; QueryAddress1 = '0; QueryAddress2 = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (LsuReady !== 1'b0) begin errors++; $display("FAIL rst_ready cyc %0d got %b exp 0", i, LsuReady); end
            checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL rst_wren cyc %0d got %b exp 0", i, WrEn); end
            checks++; if (FifoCount !== 2'd0) begin errors++; $display("FAIL rst_count cyc %0d got %0d exp 0", i, FifoCount); end
            checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL rst_stall cyc %0d got %b exp 0", i, StallReq); end
        end
        rst = 1'b0; LsuValid = 1'b0;
        tick();
        checks++; if (FifoCount !== 2'd0) begin errors++; $display("FAIL rst_noenq got %0d exp 0", FifoCount); end
        checks++; if (LsuReady !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", LsuReady); end
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL rst_wren_after got %b exp 0", WrEn); end
        checks++; if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b%b exp 00", Busy1, Busy2); end
    endtask

    task automatic test_pipe_priority();
        PipeWrEn = 1'b1; PipeWrAddress = 5'd5; PipeWrData = 32'hDEADBEEF;
        LsuValid = 1'b1; LsuWrAddress = 5'd6; LsuWrData = 32'h1234;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd5 || WrData !== 32'hDEADBEEF) begin errors++;
            $display("FAIL prio_pipe got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef", WrEn, WrAddress, WrData); end
        checks++; if (FifoCount !== 2'd1) begin errors++; $display("FAIL prio_count got %0d exp 1", FifoCount); end
        PipeWrEn = 1'b0; LsuValid = 1'b0;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd6 || WrData !== 32'h1234) begin errors++;
            $display("FAIL prio_lsu got en=%b a=%0d d=%h exp en=1 a=6 d=1234", WrEn, WrAddress, WrData); end
        checks++; if (FifoCount !== 2'd0) begin errors++; $display("FAIL prio_count2 got %0d exp 0", FifoCount); end
        tick();
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL prio_idle got %b exp 0", WrEn); end
    endtask

    task automatic test_full_stall();
        for (int k = 1; k <= 8; k++) begin
            PipeWrEn = 1'b1; PipeWrAddress = 5'(k); PipeWrData = 32'h100 + 32'(k);
            LsuValid = (k <= 2); LsuWrAddress = 5'(9 + k); LsuWrData = 32'hA00 + 32'(k);
            tick();
            checks++; if (WrEn !== 1'b1 || WrAddress !== 5'(k) || WrData !== 32'h100 + 32'(k)) begin errors++;
                $display("FAIL full_pipe k=%0d got en=%b a=%0d d=%h", k, WrEn, WrAddress, WrData); end
        end
        checks++; if (FifoCount !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", FifoCount); end
        checks++; if (LsuReady !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", LsuReady); end
        checks++; if (StallReq !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", StallReq); end
        PipeWrEn = 1'b0; LsuValid = 1'b0;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd10 || WrData !== 32'hA01) begin errors++;
            $display("FAIL drain_first got en=%b a=%0d d=%h exp en=1 a=10 d=a01", WrEn, WrAddress, WrData); end
        checks++; if (LsuReady !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", LsuReady); end
        checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL drain_stall got %b exp 0", StallReq); end
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd11 || WrData !== 32'hA02) begin errors++;
            $display("FAIL drain_second got en=%b a=%0d d=%h exp en=1 a=11 d=a02", WrEn, WrAddress, WrData); end
        checks++; if (FifoCount !== 2'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", FifoCount); end
        tick();
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", WrEn); end
    endtask

    task automatic test_starvation();
        logic exp_stall;
        PipeWrEn = 1'b1; PipeWrAddress = 5'd20; PipeWrData = 32'h2000;
        LsuValid = 1'b1; LsuWrAddress = 5'd12; LsuWrData = 32'hC0C;
        tick();
        checks++; if (FifoCount !== 2'd1 || StallReq !== 1'b0) begin errors++;
            $display("FAIL starve_enq got cnt=%0d stall=%b exp cnt=1 stall=0", FifoCount, StallReq); end
        LsuValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            PipeWrAddress = 5'(20 + i);
            tick();
            exp_stall = (i == 4);
            checks++; if (StallReq !== exp_stall || WrAddress !== 5'(20 + i)) begin errors++;
                $display("FAIL starve_wait i=%0d got stall=%b a=%0d exp stall=%b a=%0d", i, StallReq, WrAddress, exp_stall, 20 + i); end
        end
        PipeWrEn = 1'b0;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd12 || WrData !== 32'hC0C) begin errors++;
            $display("FAIL starve_pop got en=%b a=%0d d=%h exp en=1 a=12 d=c0c", WrEn, WrAddress, WrData); end
        checks++; if (StallReq !== 1'b0 || FifoCount !== 2'd0) begin errors++;
            $display("FAIL starve_clear got stall=%b cnt=%0d exp stall=0 cnt=0", StallReq, FifoCount); end
    endtask

    task automatic test_x0();
        PipeWrEn = 1'b0; LsuValid = 1'b1; LsuWrAddress = 5'd13; LsuWrData = 32'hD0D;
        tick();
        checks++; if (WrEn !== 1'b0 || FifoCount !== 2'd1) begin errors++;
            $display("FAIL x0_setup got en=%b cnt=%0d exp en=0 cnt=1", WrEn, FifoCount); end
        LsuValid = 1'b0; PipeWrEn = 1'b1; PipeWrAddress = 5'd0; PipeWrData = 32'hBAD;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd13 || WrData !== 32'hD0D) begin errors++;
            $display("FAIL x0_pipe got en=%b a=%0d d=%h exp en=1 a=13 d=d0d", WrEn, WrAddress, WrData); end
        PipeWrEn = 1'b0; LsuValid = 1'b1; LsuWrAddress = 5'd0; LsuWrData = 32'hBAD;
        #1;
        checks++; if (LsuReady !== 1'b1) begin errors++; $display("FAIL x0_lsu_ready got %b exp 1", LsuReady); end
        tick();
        LsuValid = 1'b0;
        checks++; if (FifoCount !== 2'd0 || WrEn !== 1'b0) begin errors++;
            $display("FAIL x0_lsu got cnt=%0d en=%b exp cnt=0 en=0", FifoCount, WrEn); end
        tick();
        checks++; if (WrEn !== 1'b0) begin errors++; $display("FAIL x0_lsu_nowrite got %b exp 0", WrEn); end
    endtask

    task automatic test_scoreboard();
        QueryAddress1 = 5'd7; QueryAddress2 = 5'd8;
        IssueEn = 1'b1; IssueAddress = 5'd7;
        tick();
        checks++; if (Busy1 !== SB_ON || Busy2 !== 1'b0) begin errors++;
            $display("FAIL sb_issue got b1=%b b2=%b exp b1=%b b2=0", Busy1, Busy2, SB_ON); end
        IssueEn = 1'b0; LsuValid = 1'b1; LsuWrAddress = 5'd7; LsuWrData = 32'h77;
        tick();
        checks++; if (Busy1 !== SB_ON) begin errors++; $display("FAIL sb_queued got %b exp %b", Busy1, SB_ON); end
        LsuValid = 1'b0; IssueEn = 1'b1; IssueAddress = 5'd7;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd7 || Busy1 !== SB_ON) begin errors++;
            $display("FAIL sb_setwins got en=%b a=%0d b1=%b exp en=1 a=7 b1=%b", WrEn, WrAddress, Busy1, SB_ON); end
        IssueEn = 1'b0; LsuValid = 1'b1; LsuWrData = 32'h78;
        tick();
        LsuValid = 1'b0;
        tick();
        checks++; if (WrEn !== 1'b1 || WrData !== 32'h78 || Busy1 !== 1'b0) begin errors++;
            $display("FAIL sb_clear got en=%b d=%h b1=%b exp en=1 d=78 b1=0", WrEn, WrData, Busy1); end
        IssueEn = 1'b1; IssueAddress = 5'd8;
        tick();
        IssueEn = 1'b0; PipeWrEn = 1'b1; PipeWrAddress = 5'd8; PipeWrData = 32'h88;
        tick();
        PipeWrEn = 1'b0;
        checks++; if (WrAddress !== 5'd8 || Busy2 !== SB_ON) begin errors++;
            $display("FAIL sb_pipe_noclear got a=%0d b2=%b exp a=8 b2=%b", WrAddress, Busy2, SB_ON); end
        IssueEn = 1'b1; IssueAddress = 5'd0; QueryAddress1 = 5'd0;
        tick();
        IssueEn = 1'b0;
        checks++; if (Busy1 !== 1'b0) begin errors++; $display("FAIL sb_x0 got %b exp 0", Busy1); end
    endtask

    task automatic test_reset_mid();
        LsuValid = 1'b1; LsuWrAddress = 5'd14; LsuWrData = 32'hE0E;
        tick();
        LsuValid = 1'b0; PipeWrEn = 1'b1; PipeWrAddress = 5'd9; PipeWrData = 32'h99;
        tick();
        checks++; if (WrEn !== 1'b1 || WrAddress !== 5'd9 || FifoCount !== 2'd1) begin errors++;
            $display("FAIL mid_pre got en=%b a=%0d cnt=%0d exp en=1 a=9 cnt=1", WrEn, WrAddress, FifoCount); end
        PipeWrEn = 1'b0; rst = 1'b1;
        tick();
        checks++; if (WrEn !== 1'b0 || FifoCount !== 2'd0 || LsuReady !== 1'b0 || Busy2 !== 1'b0) begin errors++;
            $display("FAIL mid_rst got en=%b cnt=%0d rdy=%b b2=%b exp 0 0 0 0", WrEn, FifoCount, LsuReady, Busy2); end
        rst = 1'b0;
        tick();
        checks++; if (WrEn !== 1'b0 || FifoCount !== 2'd0 || StallReq !== 1'b0) begin errors++;
            $display("FAIL mid_flush got en=%b cnt=%0d stall=%b exp 0 0 0", WrEn, FifoCount, StallReq); end
    endtask

    initial begin
        test_reset();
        test_pipe_priority();
        test_full_stall();
        test_starvation();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Write-side front end for the integer register file: merges the in-order pipeline writeback with a long-latency writeback source (load/store unit, divider) onto the register file's single write port. The long-latency stream is buffered in a small FIFO with a valid/ready handshake. An optional per-register scoreboard lets decode detect registers still awaiting a long-latency result. The block sits between the WB stage / LSU and the register file write port (`WrEn`/`WrAddress`/`WrData`), which commits on the falling clock edge.

## Interface
Parameters:
- `WIDTH`, 32, data width.
- `DEPTH_BITS`, 5, register address width; the register file has `1<<DEPTH_BITS` entries.
- `FIFO_DEPTH`, 2, long-latency buffer entries (≥1).
- `STARVE_LIMIT`, 4, cycles a FIFO head may wait before `StallReq` asserts.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PipeWrEn` in 1: pipeline writeback valid. No handshake; it is never back-pressured.
- `PipeWrAddress` in DEPTH_BITS: pipeline destination register.
- `PipeWrData` in WIDTH: pipeline result.
- `LsuValid` in 1: long-latency result valid.
- `LsuReady` out 1: FIFO can accept.
- `LsuWrAddress` in DEPTH_BITS: long-latency destination register.
- `LsuWrData` in WIDTH: long-latency result.
- `IssueEn` in 1: a long-latency op to `IssueAddress` was issued (scoreboard set).
- `IssueAddress` in DEPTH_BITS: that op's destination register.
- `QueryAddress1` in DEPTH_BITS: decode source register 1.
- `QueryAddress2` in DEPTH_BITS: decode source register 2.
- `Busy1` out 1: pending result for `QueryAddress1`.
- `Busy2` out 1: pending result for `QueryAddress2`.
- `StallReq` out 1: request that the pipeline withhold `PipeWrEn` next cycle.
- `WrEn` out 1: register file write port, registered.
- `WrAddress` out DEPTH_BITS: register file write port, registered.
- `WrData` out WIDTH: register file write port, registered.
- `FifoCount` out clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- **LSU handshake.** An LSU transfer occurs when `LsuValid && LsuReady` at a rising edge.
  - `LsuReady = !rst && (FifoCount < FIFO_DEPTH)`. It is combinational from state and independent of `LsuValid`.
  - An accepted transfer with `LsuWrAddress==0` is discarded. It is not enqueued and has no scoreboard effect.
- **Arbitration**, evaluated each cycle; the pipeline has absolute priority:
  - If `PipeWrEn && PipeWrAddress!=0`, the pipeline write is emitted.
  - Otherwise, if the FIFO is non-empty, the head is popped and emitted.
  - Otherwise, `WrEn` is 0.
  - A pipeline write to x0 is dropped and does not block a pop in the same cycle.
- **Simultaneous push and pop** in one cycle leaves `FifoCount` unchanged. A push into an empty FIFO cannot be emitted in the same cycle; it is eligible next cycle at the earliest.
- **Starvation counter.**
  - It counts cycles the FIFO is non-empty and not popped.
  - It resets to 0 on any pop or when the FIFO is empty.
  - `StallReq = (age >= STARVE_LIMIT) || (FifoCount == FIFO_DEPTH)`, registered.
  - If the pipeline ignores `StallReq`, the pipeline still wins. No write is ever lost.
- **Scoreboard** (see Configuration):
  - `pending[DEPTH]` bit vector.
  - `IssueEn` sets `pending[IssueAddress]`; x0 is ignored.
  - Emitting an LSU-sourced write clears `pending[WrAddress]`.
  - Simultaneous set and clear of the same register: set wins.
  - `Busy1 = pending[QueryAddress1]`, `Busy2 = pending[QueryAddress2]`, combinational. x0 always reads 0.
- **Write ordering** among same-destination pipeline and LSU writes is decode's responsibility, enforced via Busy stalls.

## Timing
- **Reset values:** `WrEn`=0, `WrAddress`=0, `WrData`=0, `StallReq`=0, `FifoCount`=0, `LsuReady`=0 while `rst` is high, all `pending`=0, `Busy1`/`Busy2`=0.
- **Latency:**
  - A pipeline write sampled at edge N appears on `WrEn`/`WrAddress`/`WrData` after edge N. The register file commits it at the falling edge in that cycle, so it is readable in the second half of cycle N+1.
  - LSU path minimum is 2 edges: enqueue, then pop and emit.
- **`WrEn` is high for exactly one cycle per write.** Back-to-back writes are allowed every cycle.
- **FIFO pointers** wrap modulo `FIFO_DEPTH`. Non-power-of-two depths are supported.
- **Reset mid-operation:** FIFO contents, age and scoreboard are flushed. An in-flight `WrEn` drops at the next edge. Transfers presented during reset are not accepted.

## Configuration
- Macro `RF_WB_SCOREBOARD_EN`.
- **Defined:** the pending vector, set/clear logic and `Busy1`/`Busy2` are as above.
- **Undefined:** no pending storage. `Busy1`/`Busy2` are tied 0. `IssueEn`, `IssueAddress`, `QueryAddress1` and `QueryAddress2` are ignored. All other behaviour is identical.

## Structure
- Shared package `rf_pkg`:
  - default `WIDTH`/`DEPTH_BITS` constants;
  - write-source enum `SRC_NONE`, `SRC_PIPE`, `SRC_LSU`;
  - a write-request struct {addr, data}.
- One sub-module, `rf_wb_fifo`: parameterized synchronous FIFO with push, pop, head, count, full and empty. Arbitration, the starvation counter and the scoreboard live in the top module.

## Test plan
- **Reset:** hold `rst` 3 cycles with `LsuValid=1` → `LsuReady=0`, `WrEn=0`, `FifoCount=0`, no enqueue.
- **Pipe priority:** `PipeWrEn=1`, x5=0xDEADBEEF and LSU x6=0x1234 in the same cycle → next cycle writes x5; the following cycle writes x6=0x1234.
- **Full/stall:** `FIFO_DEPTH=2`; pipe writes x1..x8 every cycle while LSU pushes x10 and x11 → `FifoCount=2`, `LsuReady=0`, `StallReq=1`. Then drop `PipeWrEn` → x10 then x11 emitted in order, `LsuReady` returns to 1.
- **Starvation:** one LSU entry, pipe writes every cycle → `StallReq` rises after `STARVE_LIMIT` (4) waiting cycles. Then drop `PipeWrEn` → pop, and `StallReq` clears the following cycle.
- **x0 handling:** pipe x0 write with one FIFO entry → FIFO entry emitted that cycle. LSU x0 transfer → accepted, `FifoCount` unchanged, no write.
- **Scoreboard** (macro on): `IssueEn` x7 → `Busy1=1` for `QueryAddress1=7`. LSU x7 emitted in the same cycle as a new `IssueEn` x7 → `Busy1` stays 1. Macro off → `Busy1=0` throughout.
